trim_ctrl_bank: RTL and testbench

Parametrised trim-code register bank for the analog test interface. After reset it auto-loads NCH trim codes of TW bits each from the NVM read port. It then serves test-mode read, write, increment and decrement commands addressed through R0A. It drives all trim codes in parallel to the analog macros (ADC, regulator, bias) and is the generalised successor to the fixed five-bit, single-channel trim wiring at chip top.

---
 rtl/trim_ctrl_bank.sv | 162 ++++++++++++++++
 tb/tb_trim_ctrl_bank.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trim_ctrl_bank.sv
// Trim-code register bank: NCH channels of TW bits, auto-loaded from NVM, then served by test-mode commands.
// Macro TRIM_NVMLOAD_EN enables the NVM auto-load sequence; without it channels stay at DEFVAL after reset.
module trim_ctrl_bank #(
    parameter int              NCH    = 6,
    parameter int              TW     = 5,
    parameter int              AW     = 6,
    parameter logic [TW-1:0]   DEFVAL = 5'b10000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TSTN,
    input  logic              WDWR,
    input  logic              MODEWR,
    input  logic              MODERD,
    input  logic              MODENOP,
    input  logic [1:0]        INCDECWS,
    input  logic [AW-1:0]     R0A,
    input  logic [TW-1:0]     WDATA,
    output logic [TW-1:0]     RDATA,
    output logic              RVALID,
    output logic              ERR,
    output logic              NVMREQ,
    output logic [AW-1:0]     NVMADDR,
    input  logic              NVMACK,
    input  logic [TW-1:0]     NVMDATA,
    output logic              LOADDONE,
    output logic [NCH*TW-1:0] TRMOUT
);

    typedef enum logic [1:0] {IDLE, REQ, GAP, READY} state_t;

    state_t          state_reg, state_next;
    logic            loaddone_reg, loaddone_next;
    logic [TW-1:0]   trim_reg [NCH];
    logic [TW-1:0]   rdata_reg;
    logic            rvalid_reg, err_reg;

    logic [2:0]      mode;
    logic            mode_ok, cmd, bad, cmd_ok, wr_we, rd_en;
    logic [TW-1:0]   cur_val, wr_val;

`ifdef TRIM_NVMLOAD_EN
    logic [AW-1:0]   index_reg, index_next;
    logic            load_we;
`endif

    // Command decode; anything arriving before READY is rejected without touching the load.
    assign mode    = {MODEWR, MODERD, MODENOP};
    assign mode_ok = (mode == 3'b100) || (mode == 3'b010) || (mode == 3'b001);
    assign cmd     = WDWR && !TSTN;
    assign bad     = !mode_ok || (32'(R0A) >= NCH) || (MODEWR && (INCDECWS == 2'b11));
    assign cmd_ok  = cmd && (state_reg == READY) && !bad;
    assign wr_we   = cmd_ok && MODEWR;
    assign rd_en   = cmd_ok && MODERD;

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (R0A == AW'(i)) cur_val = trim_reg[i];
        end
    end

    always_comb begin
        wr_val = cur_val;
        case (INCDECWS)
            2'b00:   wr_val = WDATA;
            2'b01:   wr_val = (cur_val == {TW{1'b1}}) ? cur_val : cur_val + TW'(1);
            2'b10:   wr_val = (cur_val == '0) ? cur_val : cur_val - TW'(1);
            default: wr_val = cur_val;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        loaddone_next = loaddone_reg;
`ifdef TRIM_NVMLOAD_EN
        index_next    = index_reg;
        load_we       = 1'b0;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (NVMACK) begin
                    load_we = 1'b1;
                    if (index_reg == AW'(NCH - 1)) begin
                        state_next    = READY;
                        loaddone_next = 1'b1;
                    end else begin
                        index_next = index_reg + AW'(1);
                        state_next = GAP;
                    end
                end
            end
            GAP:     state_next = REQ;
            default: state_next = state_reg;
        endcase
`else
        if (state_reg != READY) begin
            state_next    = READY;
            loaddone_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            loaddone_reg <= 1'b0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
            err_reg      <= 1'b0;
`ifdef TRIM_NVMLOAD_EN
            index_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            loaddone_reg <= loaddone_next;
            rvalid_reg   <= rd_en;
            err_reg      <= cmd && ((state_reg != READY) || bad);
            if (rd_en) rdata_reg <= cur_val;
`ifdef TRIM_NVMLOAD_EN
            index_reg    <= index_next;
`endif
        end
    end

    // Load writes only happen in REQ and command writes only in READY, so they never collide.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (RESET) begin
                trim_reg[i] <= DEFVAL;
`ifdef TRIM_NVMLOAD_EN
            end else if (load_we && (index_reg == AW'(i))) begin
                trim_reg[i] <= NVMDATA;
`endif
            end else if (wr_we && (R0A == AW'(i))) begin
                trim_reg[i] <= wr_val;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_trmout
            assign TRMOUT[gi*TW +: TW] = trim_reg[gi];
        end
    endgenerate

    assign RDATA    = rdata_reg;
    assign RVALID   = rvalid_reg;
    assign ERR      = err_reg;
    assign LOADDONE = loaddone_reg;

`ifdef TRIM_NVMLOAD_EN
    assign NVMREQ  = (state_reg == REQ);
    assign NVMADDR = index_reg;
`else
    logic unused_nvm;
    assign unused_nvm = ^{NVMACK, NVMDATA};
    assign NVMREQ     = 1'b0;
    assign NVMADDR    = '0;
`endif

endmodule

// File: tb/tb_trim_ctrl_bank.sv
// Self-checking bench for trim_ctrl_bank: spec-level model compared every cycle plus directed literal checks.
// Adapts to TRIM_NVMLOAD_EN the same way the design does.
module tb_trim_ctrl_bank;
    localparam int NCH  = 6;
    localparam int TW   = 5;
    localparam int AW   = 6;
    localparam int DEF  = 16;
    localparam int MAXV = (1 << TW) - 1;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              TSTN = 1'b0;
    logic              WDWR = 1'b0;
    logic              MODEWR = 1'b0;
    logic              MODERD = 1'b0;
    logic              MODENOP = 1'b0;
    logic [1:0]        INCDECWS = 2'b00;
    logic [AW-1:0]     R0A = '0;
    logic [TW-1:0]     WDATA = '0;
    logic [TW-1:0]     RDATA;
    logic              RVALID, ERR, NVMREQ, LOADDONE;
    logic [AW-1:0]     NVMADDR;
    logic              NVMACK = 1'b0;
    logic [TW-1:0]     NVMDATA = '0;
    logic [NCH*TW-1:0] TRMOUT;

    trim_ctrl_bank #(.NCH(NCH), .TW(TW), .AW(AW), .DEFVAL(5'b10000)) dut (
        .CLK(CLK), .RESET(RESET), .TSTN(TSTN), .WDWR(WDWR),
        .MODEWR(MODEWR), .MODERD(MODERD), .MODENOP(MODENOP),
        .INCDECWS(INCDECWS), .R0A(R0A), .WDATA(WDATA),
        .RDATA(RDATA), .RVALID(RVALID), .ERR(ERR),
        .NVMREQ(NVMREQ), .NVMADDR(NVMADDR), .NVMACK(NVMACK), .NVMDATA(NVMDATA),
        .LOADDONE(LOADDONE), .TRMOUT(TRMOUT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ch(input int i);
        return int'(TRMOUT[i*TW +: TW]);
    endfunction

    // NVM responder: answers each request after ack_delay cycles with 4*addr+3.
    int ack_delay = 0;
    int wait_cnt  = 0;
    int ack_count = 0;
    always @(negedge CLK) begin
        if (NVMREQ) begin
            if (wait_cnt >= ack_delay) begin
                NVMACK   = 1'b1;
                NVMDATA  = TW'(4 * int'(NVMADDR) + 3);
                wait_cnt = 0;
            end else begin
                NVMACK = 1'b0;
                wait_cnt++;
            end
        end else begin
            NVMACK   = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(posedge CLK) begin
        if (RESET) ack_count = 0;
        else if (NVMREQ && NVMACK) ack_count++;
    end

    // Behavioural model: what the outputs must be after each edge.
    int m_trim [NCH];
    int m_rdata, m_idx, m_a, m_modes;
    bit m_rvalid, m_err, m_done, m_req, m_cmd;

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NCH; i++) m_trim[i] = DEF;
            m_rdata = 0; m_rvalid = 0; m_err = 0; m_done = 0; m_req = 0; m_idx = 0;
        end else begin
            m_cmd    = WDWR && !TSTN;
            m_rvalid = 0;
            m_err    = 0;
            if (!m_done) begin
                if (m_cmd) m_err = 1;
`ifdef TRIM_NVMLOAD_EN
                if (m_req) begin
                    if (NVMACK) begin
                        m_trim[m_idx] = int'(NVMDATA);
                        m_req = 0;
                        if (m_idx == NCH - 1) m_done = 1;
                        else m_idx++;
                    end
                end else begin
                    m_req = 1;
                end
`else
                m_done = 1;
`endif
            end else if (m_cmd) begin
                m_a     = int'(R0A);
                m_modes = int'(MODEWR) + int'(MODERD) + int'(MODENOP);
                if (m_modes != 1 || m_a >= NCH || (MODEWR && INCDECWS == 2'b11)) begin
                    m_err = 1;
                end else if (MODEWR) begin
                    case (INCDECWS)
                        2'b00:   m_trim[m_a] = int'(WDATA);
                        2'b01:   if (m_trim[m_a] < MAXV) m_trim[m_a] = m_trim[m_a] + 1;
                        default: if (m_trim[m_a] > 0) m_trim[m_a] = m_trim[m_a] - 1;
                    endcase
                end else if (MODERD) begin
                    m_rdata  = m_trim[m_a];
                    m_rvalid = 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) check($sformatf("trmout[%0d]", i), ch(i), m_trim[i]);
            check("loaddone", int'(LOADDONE), int'(m_done));
            check("nvmreq", int'(NVMREQ), int'(m_req));
`ifdef TRIM_NVMLOAD_EN
            if (m_req) check("nvmaddr", int'(NVMADDR), m_idx);
`else
            check("nvmaddr", int'(NVMADDR), 0);
`endif
            check("err", int'(ERR), int'(m_err));
            check("rvalid", int'(RVALID), int'(m_rvalid));
            check("rdata", int'(RDATA), m_rdata);
        end
    end

    task automatic cmd(input bit wr, input bit rd, input bit nop, input logic [1:0] ids,
                       input int addr, input int data, input bit tstn);
        @(negedge CLK);
        WDWR = 1'b1; MODEWR = wr; MODERD = rd; MODENOP = nop;
        INCDECWS = ids; R0A = AW'(addr); WDATA = TW'(data); TSTN = tstn;
        $display("cmd t=%0t wr=%0b rd=%0b nop=%0b ids=%0d addr=%0d data=%0d tstn=%0b",
                 $time, wr, rd, nop, ids, addr, data, tstn);
    endtask

    task automatic idle();
        @(negedge CLK);
        WDWR = 1'b0; MODEWR = 1'b0; MODERD = 1'b0; MODENOP = 1'b0; TSTN = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!LOADDONE && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!LOADDONE) check({name, "_timeout"}, 0, 1);
        $display("load %s finished after %0d cycles", name, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RESET = 1'b1;
        @(posedge CLK);
        chk_en = 1'b1;
        @(negedge CLK);
        check("rst_trm0", ch(0), 16);
        check("rst_trm5", ch(5), 16);
        check("rst_loaddone", int'(LOADDONE), 0);
        check("rst_nvmreq", int'(NVMREQ), 0);
        check("rst_nvmaddr", int'(NVMADDR), 0);
        check("rst_rdata", int'(RDATA), 0);
        check("rst_err", int'(ERR), 0);

`ifdef TRIM_NVMLOAD_EN
        ack_delay = 0;
        RESET = 1'b0;
        wait_done("delay0");
        check("load0_ch0", ch(0), 3);
        check("load0_ch3", ch(3), 15);
        check("load0_ch5", ch(5), 23);

        // Slow NVM, commands during load, then reset after the third ACK.
        RESET = 1'b1; ack_delay = 3;
        @(negedge CLK);
        RESET = 1'b0;
        cmd(1, 0, 0, 2'b00, 0, 9, 0);
        idle();
        check("load_cmd_err", int'(ERR), 1);
        cmd(1, 0, 0, 2'b00, 0, 9, 1);
        idle();
        check("load_cmd_tstn1_noerr", int'(ERR), 0);
        n = 0;
        while (ack_count < 3 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("third_ack_seen", int'(ack_count >= 3), 1);
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_ch0", ch(0), 16);
        check("midrst_ch2", ch(2), 16);
        check("midrst_nvmaddr", int'(NVMADDR), 0);
        check("midrst_loaddone", int'(LOADDONE), 0);
        RESET = 1'b0;
        wait_done("delay3");
        check("load3_ch2", ch(2), 11);
        check("load3_ch5", ch(5), 23);
`else
        RESET = 1'b0;
        @(negedge CLK);
        check("nomacro_done_1cyc", int'(LOADDONE), 1);
        check("nomacro_nvmreq", int'(NVMREQ), 0);
        cmd(1, 0, 0, 2'b00, 4, 12, 0);
        idle();
        check("nomacro_wr_ch4", ch(4), 12);
        check("nomacro_wr_noerr", int'(ERR), 0);
`endif

        // Write then read same channel back-to-back.
        cmd(1, 0, 0, 2'b00, 2, 9, 0);
        cmd(0, 1, 0, 2'b00, 2, 0, 0);
        idle();
        check("rd_rdata", int'(RDATA), 9);
        check("rd_rvalid", int'(RVALID), 1);
        idle();
        check("rd_rvalid_pulse", int'(RVALID), 0);
        check("rd_rdata_held", int'(RDATA), 9);

        // Saturation.
        cmd(1, 0, 0, 2'b00, 0, 31, 0);
        cmd(1, 0, 0, 2'b01, 0, 0, 0);
        cmd(1, 0, 0, 2'b00, 1, 0, 0);
        cmd(1, 0, 0, 2'b10, 1, 0, 0);
        cmd(1, 0, 0, 2'b00, 3, 5, 0);
        cmd(1, 0, 0, 2'b01, 3, 0, 0);
        cmd(1, 0, 0, 2'b01, 3, 0, 0);
        idle();
        check("sat_inc_ch0", ch(0), 31);
        check("sat_dec_ch1", ch(1), 0);
        check("inc2_ch3", ch(3), 7);

        // Error commands and their TSTN=1 twins.
        cmd(1, 0, 0, 2'b00, 6, 1, 0);
        idle();
        check("err_addr", int'(ERR), 1);
        cmd(1, 1, 0, 2'b00, 2, 1, 0);
        idle();
        check("err_mode", int'(ERR), 1);
        cmd(1, 0, 0, 2'b11, 2, 1, 0);
        idle();
        check("err_ids", int'(ERR), 1);
        check("err_ch2_kept", ch(2), 9);
        cmd(0, 0, 1, 2'b00, 2, 1, 0);
        idle();
        check("nop_noerr", int'(ERR), 0);
        check("nop_norvalid", int'(RVALID), 0);
        cmd(1, 0, 0, 2'b00, 6, 1, 1);
        idle();
        check("tstn1_addr_noerr", int'(ERR), 0);
        cmd(1, 1, 0, 2'b11, 2, 1, 1);
        idle();
        check("tstn1_mode_noerr", int'(ERR), 0);
        check("tstn1_ch2_kept", ch(2), 9);
`ifdef TRIM_NVMLOAD_EN
        check("ch5_kept", ch(5), 23);
`else
        check("ch5_kept", ch(5), 16);
`endif
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
